// File: rtl/cc_bus_pkg.sv
// Shared definitions for the datapath bus and its reader.
//   DATAWIDTH_BUS_DEF : default bus word width (32)
//   DEPTH_LOG2_DEF    : default log2 of the reader FIFO depth (2 -> 4 words)
//   countWidth()      : width of an occupancy count that can hold 0..2**depthLog2
//   busWord_t         : data word type shared with the bus source
package cc_bus_pkg;

  localparam int DATAWIDTH_BUS_DEF = 32;
  localparam int DEPTH_LOG2_DEF    = 2;

  // One extra bit so a completely full FIFO is distinguishable from empty.
  function automatic int countWidth(input int depthLog2);
    return depthLog2 + 1;
  endfunction

  typedef logic [DATAWIDTH_BUS_DEF-1:0] busWord_t;

endpackage

// File: rtl/cc_bus_reader_mem.sv
// Register-array storage for the bus reader FIFO.
// Ports:
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : asynchronous read data (mem[raddr])
// Contents are not reset; the owner tracks which entries are valid.
module cc_bus_reader_mem #(
  parameter int DATAW = 32,
  parameter int ADDRW = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDRW-1:0] waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic [ADDRW-1:0] raddr,
  output logic [DATAW-1:0] rdata
);

  localparam int DEPTH = 1 << ADDRW;

  logic [DEPTH-1:0][DATAW-1:0] mem;

  for (genvar i = 0; i < DEPTH; i++) begin : gEntry
    always_ff @(posedge clk) begin
      if (we && (waddr == ADDRW'(i))) mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cc_bus_reader.sv
// Bus reader: captures words strobed onto the datapath bus into a small FIFO
// and hands them to a downstream consumer with a valid/accept handshake.
// Ports:
//   CC_BUSREADER_CLOCK_50      : clock, rising edge
//   CC_BUSREADER_RESET_InHigh  : asynchronous active-high reset
//   CC_BUSREADER_DataBUS_In    : word on the bus
//   CC_BUSREADER_Load_In       : capture the bus word at this edge
//   CC_BUSREADER_Ready_Out     : FIFO not full
//   CC_BUSREADER_DataBUS_Out   : head word (0 when not valid)
//   CC_BUSREADER_Valid_Out     : FIFO not empty
//   CC_BUSREADER_Accept_In     : consumer takes the head word at this edge
//   CC_BUSREADER_Clear_In      : synchronous flush (beats load/accept)
//   CC_BUSREADER_Count_Out     : words held, 0..2**DEPTH_LOG2
//   CC_BUSREADER_Overflow_Out  : sticky, a word was dropped
// Optional (macro CC_BUSREADER_PARITY_EN):
//   CC_BUSREADER_Parity_In     : even parity bit for DataBUS_In
//   CC_BUSREADER_ParityErr_Out : sticky, a stored word had bad parity
module cc_bus_reader
  import cc_bus_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
  parameter int DEPTH_LOG2    = DEPTH_LOG2_DEF
) (
  input  logic                     CC_BUSREADER_CLOCK_50,
  input  logic                     CC_BUSREADER_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] CC_BUSREADER_DataBUS_In,
  input  logic                     CC_BUSREADER_Load_In,
  output logic                     CC_BUSREADER_Ready_Out,
  output logic [DATAWIDTH_BUS-1:0] CC_BUSREADER_DataBUS_Out,
  output logic                     CC_BUSREADER_Valid_Out,
  input  logic                     CC_BUSREADER_Accept_In,
  input  logic                     CC_BUSREADER_Clear_In,
  output logic [DEPTH_LOG2:0]      CC_BUSREADER_Count_Out,
  output logic                     CC_BUSREADER_Overflow_Out
`ifdef CC_BUSREADER_PARITY_EN
  ,
  input  logic                     CC_BUSREADER_Parity_In,
  output logic                     CC_BUSREADER_ParityErr_Out
`endif
);

  localparam int              CW    = countWidth(DEPTH_LOG2);
  localparam logic [CW-1:0]   DEPTH = CW'(1 << DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0]    wp, rp;
  logic [CW-1:0]            count;
  logic                     overflow;
  logic                     full, empty, rd, wr, drop;
  logic [DATAWIDTH_BUS-1:0] headWord;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign rd    = CC_BUSREADER_Accept_In && !empty;
  // A load into a full FIFO still lands if the head leaves on the same edge.
  assign wr    = CC_BUSREADER_Load_In && (!full || rd);
  assign drop  = CC_BUSREADER_Load_In && full && !rd;

  always_ff @(posedge CC_BUSREADER_CLOCK_50 or posedge CC_BUSREADER_RESET_InHigh) begin
    if (CC_BUSREADER_RESET_InHigh) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (CC_BUSREADER_Clear_In) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Clear blocks the array write too, so a flushed load never reappears.
  cc_bus_reader_mem #(
    .DATAW(DATAWIDTH_BUS),
    .ADDRW(DEPTH_LOG2)
  ) uMem (
    .clk  (CC_BUSREADER_CLOCK_50),
    .we   (wr && !CC_BUSREADER_Clear_In),
    .waddr(wp),
    .wdata(CC_BUSREADER_DataBUS_In),
    .raddr(rp),
    .rdata(headWord)
  );

`ifdef CC_BUSREADER_PARITY_EN
  logic parityErr;

  // Even parity: Parity_In must equal the XOR of the data bits.
  always_ff @(posedge CC_BUSREADER_CLOCK_50 or posedge CC_BUSREADER_RESET_InHigh) begin
    if (CC_BUSREADER_RESET_InHigh)                                  parityErr <= 1'b0;
    else if (CC_BUSREADER_Clear_In)                                 parityErr <= 1'b0;
    else if (wr && (CC_BUSREADER_Parity_In != ^CC_BUSREADER_DataBUS_In)) parityErr <= 1'b1;
  end

  assign CC_BUSREADER_ParityErr_Out = parityErr;
`else
  // No parity checking in this build.
`endif

  assign CC_BUSREADER_Ready_Out    = !full;
  assign CC_BUSREADER_Valid_Out    = !empty;
  assign CC_BUSREADER_Count_Out    = count;
  assign CC_BUSREADER_Overflow_Out = overflow;
  assign CC_BUSREADER_DataBUS_Out  = empty ? '0 : headWord;

endmodule

// File: doc/cc_bus_reader.md
# cc_bus_reader

Receiving end of the datapath data bus: captures words driven onto the combinational `DATAWIDTH_BUS`-wide bus when the source strobes a load. Buffers them in a small FIFO and presents them to a downstream consumer with a valid/accept handshake. It sits between the bus and any slow sink, such as a register bank write port or an output peripheral, so the bus source never stalls for a single-cycle consumer delay.

## Interface
Parameters:
- `DATAWIDTH_BUS`, default 32: width of every data word.
- `DEPTH_LOG2`, default 2: log2 of the FIFO depth (default depth is 4 words).

Ports:
- `CC_BUSREADER_CLOCK_50`, in, 1: the single clock. All state updates on its rising edge.
- `CC_BUSREADER_RESET_InHigh`, in, 1: asynchronous, active-high reset.
- `CC_BUSREADER_DataBUS_In`, in, `DATAWIDTH_BUS`: word currently on the bus.
- `CC_BUSREADER_Load_In`, in, 1: capture `DataBUS_In` at this edge.
- `CC_BUSREADER_Ready_Out`, out, 1: FIFO not full.
- `CC_BUSREADER_DataBUS_Out`, out, `DATAWIDTH_BUS`: head word. Reads 0 when `Valid_Out` is 0.
- `CC_BUSREADER_Valid_Out`, out, 1: FIFO not empty.
- `CC_BUSREADER_Accept_In`, in, 1: consumer takes the head word at this edge.
- `CC_BUSREADER_Clear_In`, in, 1: synchronous flush.
- `CC_BUSREADER_Count_Out`, out, `DEPTH_LOG2+1`: number of words held (0 to `2**DEPTH_LOG2`).
- `CC_BUSREADER_Overflow_Out`, out, 1: sticky flag, set when a word is dropped.

## Operation
Storage and pointers:
- Storage is a `2**DEPTH_LOG2`-entry register array.
- Write pointer `wp` and read pointer `rp` are each `DEPTH_LOG2` bits wide and wrap modulo the depth.
- A `DEPTH_LOG2+1`-bit count is held in a register.
- Full is count == depth. Empty is count == 0.

Per-edge events:
- **Write**: occurs when `Load_In` && (!full || rd). Then `mem[wp] <= DataBUS_In` and `wp++`.
- **Read (rd)**: occurs when `Accept_In` && !empty, and `rp++`. `Accept_In` while empty is ignored.
- **Count update**: +1 on write only, -1 on read only, unchanged when both or neither occur.
- **Simultaneous load and accept while full**: both happen and the count stays at depth. `Ready_Out` is low in this case, but a source that loads anyway is not penalised.
- **Overflow**: `Load_In` while full and no read drops the word. `Overflow_Out` goes to 1 and stays there until Clear or reset.
- **Clear**: has priority over Load and Accept. It zeroes `wp`, `rp`, count and `Overflow_Out`. Array contents are don't-care.
- **Outputs**: `Ready_Out`, `Valid_Out` and `Count_Out` are decoded from registered state only. There are no combinational paths from `Load_In` or `Accept_In`.
- **Reset**: asynchronously zeroes `wp`, `rp`, count, `Overflow_Out` (and `ParityErr_Out`). Outputs after reset: `Ready_Out`=1, `Valid_Out`=0, `DataBUS_Out`=0, `Count_Out`=0, `Overflow_Out`=0. Reset during any transfer discards all held words.

## Timing
Latency:
- A word loaded at edge k appears on `DataBUS_Out` with `Valid_Out`=1 after edge k, i.e. one cycle load-to-valid.
- After an accept at edge k, the next word or empty status is visible after edge k.

Throughput and ordering:
- Sustained throughput is one word per cycle in each direction.
- Ordering is strict FIFO. Words do not bypass the FIFO.
- `Ready_Out` deasserts in the cycle after the edge that fills the FIFO.

## Configuration
- `CC_BUSREADER_PARITY_EN` defined:
  - Adds input `CC_BUSREADER_Parity_In` (1 bit, even parity over `DataBUS_In`, sampled with `Load_In`) and output `CC_BUSREADER_ParityErr_Out` (sticky).
  - On a write whose parity mismatches, `ParityErr_Out` goes to 1. The word is still stored.
  - `ParityErr_Out` is cleared by Clear or reset.
- Macro undefined: neither port exists and no parity logic is built.

## Structure
- Package `cc_bus_pkg` holds:
  - the default `DATAWIDTH_BUS` (32) and `DEPTH_LOG2` (2) constants;
  - a count-width constant/function (`DEPTH_LOG2+1`);
  - the data word typedef shared with the bus source.
- One natural sub-module: `cc_bus_reader_mem`. It contains the register array with write port (`we`, `waddr`, `wdata`) and an asynchronous read port (`raddr`, `rdata`).
- Pointer, count and flag logic stays in `cc_bus_reader`.

## Test plan
- **Reset**: assert reset mid-stream with count = 3 → immediately `Valid_Out`=0, `Count_Out`=0, `Ready_Out`=1, `DataBUS_Out`=0, `Overflow_Out`=0.
- **Basic order**: load 0x11, 0x22, 0x33 on consecutive edges, then accept three times → outputs 0x11, 0x22, 0x33 in order. `Valid_Out` is 1 from the cycle after the first load, and `Count_Out` peaks at 3.
- **Full and wrap**: load 0xA0 to 0xA3 (FIFO full, `Ready_Out`=0), then accept and load 0xA4 on the same edge → count stays 4, `Overflow_Out`=0. Draining yields 0xA1, 0xA2, 0xA3, 0xA4.
- **Overflow**: with the FIFO full, load 0xDEAD with no accept → `Overflow_Out`=1, the word is dropped, and draining returns the original 4 words. Pulsing Clear afterwards → count 0, `Overflow_Out`=0.
- **Edge handshakes**: accept while empty → no change, count stays 0. Clear and Load on the same edge → count 0, `Valid_Out`=0.
- **Parity (`CC_BUSREADER_PARITY_EN`)**: load 0x00000001 with `Parity_In`=0 → `ParityErr_Out`=1 and the word is still read out as 0x00000001. Load 0x00000003 with `Parity_In`=0 after a Clear → `ParityErr_Out` stays 0.
